sdram_bus_arbiter: RTL and testbench
====================================

Name: sdram_bus_arbiter

Overview:
- Parametrised N-channel arbiter in front of the ip_sdram bus port (bus_address[22:2], valid/write/refresh, 32-bit data, byte mask, rdata_en).
- Lets the VDP VRAM port share one SDRAM with further masters, e.g. a host/debug VRAM port or a future CPU-side RAM mapper.
- Issues at most one command per fixed slot, gives refresh top priority, and routes each read return to the channel that issued it using an in-order tag FIFO.

Parameters:
- NUM_CH, 2: number of requesting channels (1..8); channel 0 is the VDP.
- ADDR_W, 21: word-address width (maps to bus_address[22:2]).
- SLOT_CYCLES, 4: minimum clk cycles between issued commands (>=2).
- RD_DEPTH, 4: maximum outstanding reads (power of two, >=2).

Ports:
- clk  in  1  85.90908 MHz system clock.
- reset_n  in  1  asynchronous active-low reset.
- initial_busy  in  1  SDRAM init in progress; no command is issued while it is 1.
- ch_valid  in  NUM_CH  per-channel request; held until ch_ready.
- ch_ready  out  NUM_CH  one-cycle grant pulse, registered.
- ch_write  in  NUM_CH  1 = write, 0 = read.
- ch_address  in  NUM_CH*ADDR_W  packed; channel i occupies [i*ADDR_W +: ADDR_W].
- ch_wdata  in  NUM_CH*32  packed write data.
- ch_wdata_mask  in  NUM_CH*4  packed byte mask (1 = byte masked).
- ch_rdata  out  32  read data, shared by all channels.
- ch_rdata_en  out  NUM_CH  one-cycle read-return strobe to the owning channel.
- refresh_req  in  1  refresh request; held until refresh_ack.
- refresh_ack  out  1  one-cycle acknowledge.
- sdram_address  out  ADDR_W  to ip_sdram bus_address.
- sdram_valid  out  1  one-cycle command strobe.
- sdram_write  out  1  command direction.
- sdram_refresh  out  1  one-cycle refresh strobe.
- sdram_wdata  out  32  write data.
- sdram_wdata_mask  out  4  write byte mask.
- sdram_rdata  in  32  read data from ip_sdram.
- sdram_rdata_en  in  1  read-return strobe from ip_sdram.
- rd_pending  out  $clog2(RD_DEPTH)+1  outstanding read count.
- err_orphan  out  1  sticky: rdata_en arrived with no outstanding read.

Behaviour:
- Reset values: every output 0, FSM in IDLE, slot counter 0, tag FIFO empty, round-robin pointer 0.
- FSM states:
  - IDLE: entered when the slot counter is 0 and initial_busy is 0. Decision is made in cycle t.
  - ISSUE: lasts 1 cycle (t+1) and drives the registered outputs.
  - GAP: lasts SLOT_CYCLES-2 cycles, then returns to IDLE. Command-to-command spacing is exactly SLOT_CYCLES when requests are continuous.
- Priority in IDLE:
  - refresh_req wins: ISSUE drives sdram_refresh=1 and refresh_ack=1; sdram_valid stays 0.
  - Otherwise arbitration picks a winner; ISSUE drives sdram_valid=1, write/address/wdata/mask from the winner, and ch_ready[winner]=1.
  - With no requests, stay in IDLE and the slot counter does not run.
- Eligibility: channel i is eligible when ch_valid[i]=1. A read is additionally ineligible while the tag FIFO holds RD_DEPTH entries. Writes are never blocked by a full FIFO.
- Round-robin: search starts at the pointer; after a grant the pointer becomes winner+1 modulo NUM_CH.
- Command fields are captured in cycle t. Channel inputs are ignored during ISSUE and GAP, so a requester still holding valid during ISSUE is never granted twice.
- Read tagging: a granted read pushes the channel index into the tag FIFO during ISSUE.
- Read return: on sdram_rdata_en, the arbiter pops the head tag. It drives ch_rdata_en[tag]=1 and ch_rdata=sdram_rdata one cycle later (registered, +1 latency). Returns are strictly in issue order.
- Push and pop in the same cycle: the count is unchanged and both operations take effect.
- rdata_en with an empty FIFO: the return is dropped, no ch_rdata_en is asserted, and err_orphan is set. err_orphan clears only on reset.
- initial_busy rising mid-slot: the current ISSUE/GAP completes; no new decision is made until it falls. Reads already issued still route.
- Reset asserted mid-operation: all outputs clear immediately and pending tags are discarded. Late returns after reset release set err_orphan.
- rd_pending equals the FIFO occupancy (0..RD_DEPTH).

Optional Feature:
- Macro: SDRAM_ARB_FIXED_PRIORITY_EN.
- Defined: strict fixed priority, lowest index wins (VDP always first). The round-robin pointer is removed. Refresh still outranks all channels.
- Undefined: round-robin as described above.

Test Plan:
- Single read, ch0, address 0x00123, SLOT_CYCLES=4 -> ch_ready[0] and sdram_valid one cycle after request; model returns 0xDEADBEEF -> ch_rdata_en[0]=1 with that data one cycle after rdata_en; rd_pending 1 then 0.
- ch0 and ch1 request continuously (round-robin build) -> grants alternate 0,1,0,1 exactly 4 cycles apart; fixed-priority build -> only ch0 granted while it requests.
- refresh_req together with both channels -> the first slot is sdram_refresh with refresh_ack; channel grants resume in the following slots.
- 5 back-to-back reads from ch1 with RD_DEPTH=4 and a stalled return -> 4 issued, the 5th held off while a ch0 write is still granted; one return -> the 5th read issues.
- Interleaved reads ch0@0x10, ch1@0x20, ch0@0x30 -> returns routed to ch0, ch1, ch0 in order; unsolicited rdata_en -> err_orphan=1 and no strobe.
- initial_busy=1 for 100 cycles with requests pending -> no sdram_valid; first grant 1 cycle after it falls. Reset asserted during GAP -> all outputs 0 and rd_pending 0.

Source files
------------

// File: rtl/sdram_bus_arbiter_if.sv
// Channel-side request/return bus and ip_sdram command bus for sdram_bus_arbiter.
// slave = arbiter view, master = requesters plus SDRAM controller view.
interface sdram_bus_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 21
);
  logic [NUM_CH-1:0]        ch_valid;
  logic [NUM_CH-1:0]        ch_ready;
  logic [NUM_CH-1:0]        ch_write;
  logic [NUM_CH*ADDR_W-1:0] ch_address;
  logic [NUM_CH*32-1:0]     ch_wdata;
  logic [NUM_CH*4-1:0]      ch_wdata_mask;
  logic [31:0]              ch_rdata;
  logic [NUM_CH-1:0]        ch_rdata_en;
  logic                     refresh_req;
  logic                     refresh_ack;
  logic [ADDR_W-1:0]        sdram_address;
  logic                     sdram_valid;
  logic                     sdram_write;
  logic                     sdram_refresh;
  logic [31:0]              sdram_wdata;
  logic [3:0]               sdram_wdata_mask;
  logic [31:0]              sdram_rdata;
  logic                     sdram_rdata_en;

  modport slave (
    input  ch_valid, ch_write, ch_address, ch_wdata, ch_wdata_mask, refresh_req,
           sdram_rdata, sdram_rdata_en,
    output ch_ready, ch_rdata, ch_rdata_en, refresh_ack, sdram_address, sdram_valid,
           sdram_write, sdram_refresh, sdram_wdata, sdram_wdata_mask
  );

  modport master (
    output ch_valid, ch_write, ch_address, ch_wdata, ch_wdata_mask, refresh_req,
           sdram_rdata, sdram_rdata_en,
    input  ch_ready, ch_rdata, ch_rdata_en, refresh_ack, sdram_address, sdram_valid,
           sdram_write, sdram_refresh, sdram_wdata, sdram_wdata_mask
  );
endinterface

// File: rtl/sdram_bus_arbiter.sv
// Slotted N-channel arbiter in front of ip_sdram; refresh first, in-order read-return routing.
// Define SDRAM_ARB_FIXED_PRIORITY_EN for strict lowest-index-first priority instead of round-robin.
module sdram_bus_arbiter #(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 21,
  parameter int SLOT_CYCLES = 4,
  parameter int RD_DEPTH    = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        initial_busy,
  sdram_bus_arbiter_if.slave          bus,
  output logic [$clog2(RD_DEPTH):0]   rd_pending,
  output logic                        err_orphan
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW    = $clog2(RD_DEPTH);
  localparam int CNT_W = PW + 1;
  localparam int SW    = $clog2(SLOT_CYCLES);
  localparam logic [SW-1:0] SLOT_LD = SW'((SLOT_CYCLES > 2) ? SLOT_CYCLES - 3 : 0);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_e;

  state_e              state_q, state_d;
  logic [SW-1:0]       slot_q, slot_d;
  logic                grant_go, refresh_go;
  logic                gnt_found;
  logic [CH_W-1:0]     gnt_idx;
  logic [NUM_CH-1:0]   elig;

  logic                valid_q, write_q, refresh_q;
  logic [NUM_CH-1:0]   ready_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [3:0]          mask_q;
  logic [CH_W-1:0]     gidx_q;

  logic [CH_W-1:0]     tags_q [RD_DEPTH];
  logic [PW-1:0]       wr_q, rd_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                fifo_full, push, pop, orphan;
  logic [31:0]         rdata_q;
  logic [NUM_CH-1:0]   rdata_en_q;
  logic                err_q;

  assign fifo_full = (count_q == CNT_W'(RD_DEPTH));
  assign elig      = bus.ch_valid & (bus.ch_write | {NUM_CH{~fifo_full}});

`ifdef SDRAM_ARB_FIXED_PRIORITY_EN
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!gnt_found && elig[k]) begin
        gnt_found = 1'b1;
        gnt_idx   = CH_W'(k);
      end
    end
  end
`else
  logic [CH_W-1:0] ptr_q;

  always_comb begin
    int c;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    c         = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      c = (int'(ptr_q) + k) % NUM_CH;
      if (!gnt_found && elig[c]) begin
        gnt_found = 1'b1;
        gnt_idx   = CH_W'(c);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else if (grant_go) ptr_q <= (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
  end
`endif

  // Only IDLE looks at channel inputs, so a requester held through ISSUE/GAP is granted once.
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    grant_go   = 1'b0;
    refresh_go = 1'b0;
    case (state_q)
      IDLE: begin
        if (!initial_busy) begin
          if (bus.refresh_req) begin
            refresh_go = 1'b1;
            state_d    = ISSUE;
          end else if (gnt_found) begin
            grant_go = 1'b1;
            state_d  = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (SLOT_CYCLES > 2) begin
          state_d = GAP;
          slot_d  = SLOT_LD;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (slot_q == '0) state_d = IDLE;
        else              slot_d  = slot_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      slot_q    <= '0;
      valid_q   <= 1'b0;
      write_q   <= 1'b0;
      refresh_q <= 1'b0;
      ready_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mask_q    <= '0;
      gidx_q    <= '0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      valid_q   <= grant_go;
      refresh_q <= refresh_go;
      ready_q   <= '0;
      if (grant_go) begin
        ready_q[gnt_idx] <= 1'b1;
        write_q <= bus.ch_write[gnt_idx];
        addr_q  <= bus.ch_address[gnt_idx*ADDR_W +: ADDR_W];
        wdata_q <= bus.ch_wdata[gnt_idx*32 +: 32];
        mask_q  <= bus.ch_wdata_mask[gnt_idx*4 +: 4];
        gidx_q  <= gnt_idx;
      end
    end
  end

  // Tag FIFO: a push can never hit a full FIFO because reads are only granted below depth.
  assign push    = (state_q == ISSUE) && valid_q && !write_q;
  assign pop     = bus.sdram_rdata_en && (count_q != '0);
  assign orphan  = bus.sdram_rdata_en && (count_q == '0);
  assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge clk) begin
    if (push) tags_q[wr_q] <= gidx_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      rdata_q    <= '0;
      rdata_en_q <= '0;
      err_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      rdata_en_q <= '0;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) begin
        rd_q                   <= rd_q + 1'b1;
        rdata_q                <= bus.sdram_rdata;
        rdata_en_q[tags_q[rd_q]] <= 1'b1;
      end
      if (orphan) err_q <= 1'b1;
    end
  end

  assign bus.ch_ready         = ready_q;
  assign bus.ch_rdata         = rdata_q;
  assign bus.ch_rdata_en      = rdata_en_q;
  assign bus.refresh_ack      = refresh_q;
  assign bus.sdram_refresh    = refresh_q;
  assign bus.sdram_valid      = valid_q;
  assign bus.sdram_write      = write_q;
  assign bus.sdram_address    = addr_q;
  assign bus.sdram_wdata      = wdata_q;
  assign bus.sdram_wdata_mask = mask_q;
  assign rd_pending           = count_q;
  assign err_orphan           = err_q;
endmodule

// File: tb/tb_sdram_bus_arbiter.sv
// Directed bench for sdram_bus_arbiter (NUM_CH=2, SLOT_CYCLES=4, RD_DEPTH=4).
module tb_sdram_bus_arbiter;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       initial_busy = 1'b0;
  logic [2:0] rd_pending;
  logic       err_orphan;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  sdram_bus_arbiter_if #(.NUM_CH(2), .ADDR_W(21)) ifc ();

  sdram_bus_arbiter #(.NUM_CH(2), .ADDR_W(21), .SLOT_CYCLES(4), .RD_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .initial_busy(initial_busy), .bus(ifc.slave),
    .rd_pending(rd_pending), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifc.ch_valid = '0; ifc.ch_write = '0; ifc.ch_address = '0; ifc.ch_wdata = '0;
    ifc.ch_wdata_mask = '0; ifc.refresh_req = 1'b0; ifc.sdram_rdata = '0; ifc.sdram_rdata_en = 1'b0;
    initial_busy = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Advance until a command or refresh strobe appears, at most lim cycles.
  task automatic wait_cmd(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      tick();
      if (ifc.sdram_valid || ifc.sdram_refresh) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic return_one(input logic [31:0] d);
    ifc.sdram_rdata = d; ifc.sdram_rdata_en = 1'b1;
    tick();
    ifc.sdram_rdata_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ifc.sdram_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", ifc.sdram_valid); end
    checks++; if (ifc.ch_ready !== 2'b00) begin errors++; $display("FAIL rst_ready got %b exp 00", ifc.ch_ready); end
    checks++; if (ifc.refresh_ack !== 1'b0 || ifc.sdram_refresh !== 1'b0) begin errors++; $display("FAIL rst_refresh got %b%b exp 00", ifc.refresh_ack, ifc.sdram_refresh); end
    checks++; if (rd_pending !== 3'd0) begin errors++; $display("FAIL rst_pending got %0d exp 0", rd_pending); end
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL rst_orphan got %b exp 0", err_orphan); end
    checks++; if (ifc.ch_rdata_en !== 2'b00 || ifc.sdram_address !== 21'h0) begin errors++; $display("FAIL rst_misc got en=%b addr=%h exp 0", ifc.ch_rdata_en, ifc.sdram_address); end
  endtask

  task automatic test_single_read();
    bit ok;
    int t0;
    do_reset();
    ifc.ch_valid = 2'b01; ifc.ch_write = 2'b00; ifc.ch_address[0 +: 21] = 21'h00123;
    t0 = cyc;
    wait_cmd(10, ok);
    checks++; if (!ok || cyc - t0 !== 1) begin errors++; $display("FAIL sr_latency got ok=%b dt=%0d exp 1", ok, cyc - t0); end
    checks++; if (ifc.ch_ready !== 2'b01 || ifc.sdram_write !== 1'b0) begin errors++; $display("FAIL sr_grant got rdy=%b wr=%b exp 01/0", ifc.ch_ready, ifc.sdram_write); end
    checks++; if (ifc.sdram_address !== 21'h00123) begin errors++; $display("FAIL sr_addr got %h exp 00123", ifc.sdram_address); end
    ifc.ch_valid = 2'b00;
    tick();
    checks++; if (rd_pending !== 3'd1 || ifc.sdram_valid !== 1'b0) begin errors++; $display("FAIL sr_pending got %0d v=%b exp 1/0", rd_pending, ifc.sdram_valid); end
    tick(); tick();
    return_one(32'hDEADBEEF);
    checks++; if (ifc.ch_rdata_en !== 2'b01 || ifc.ch_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sr_return got en=%b d=%h exp 01/deadbeef", ifc.ch_rdata_en, ifc.ch_rdata); end
    checks++; if (rd_pending !== 3'd0) begin errors++; $display("FAIL sr_drain got %0d exp 0", rd_pending); end
    tick();
    checks++; if (ifc.ch_rdata_en !== 2'b00) begin errors++; $display("FAIL sr_strobe_len got %b exp 00", ifc.ch_rdata_en); end
  endtask

  task automatic test_arbitration();
    bit ok;
    int tprev;
    logic [1:0] exp_rdy;
    do_reset();
    ifc.ch_valid = 2'b11; ifc.ch_write = 2'b11;
    ifc.ch_address[0 +: 21] = 21'h0AAAA; ifc.ch_address[21 +: 21] = 21'h15555;
    tprev = cyc;
    for (int g = 0; g < 4; g++) begin
`ifdef SDRAM_ARB_FIXED_PRIORITY_EN
      exp_rdy = 2'b01;
`else
      exp_rdy = (g % 2 == 0) ? 2'b01 : 2'b10;
`endif
      wait_cmd(10, ok);
      checks++; if (!ok || ifc.ch_ready !== exp_rdy) begin errors++; $display("FAIL arb_grant%0d got ok=%b rdy=%b exp %b", g, ok, ifc.ch_ready, exp_rdy); end
      checks++; if (ifc.sdram_address !== ((exp_rdy == 2'b01) ? 21'h0AAAA : 21'h15555)) begin errors++; $display("FAIL arb_addr%0d got %h", g, ifc.sdram_address); end
      if (g > 0) begin
        checks++; if (cyc - tprev !== 4) begin errors++; $display("FAIL arb_spacing%0d got %0d exp 4", g, cyc - tprev); end
      end
      tprev = cyc;
    end
    ifc.ch_valid = 2'b00;
    repeat (4) tick();
  endtask

  task automatic test_refresh();
    bit ok;
    int t0;
    do_reset();
    ifc.ch_valid = 2'b11; ifc.ch_write = 2'b11; ifc.refresh_req = 1'b1;
    wait_cmd(10, ok);
    checks++; if (!ok || ifc.sdram_refresh !== 1'b1 || ifc.refresh_ack !== 1'b1) begin errors++; $display("FAIL ref_strobe got ok=%b ref=%b ack=%b exp 1/1", ok, ifc.sdram_refresh, ifc.refresh_ack); end
    checks++; if (ifc.sdram_valid !== 1'b0 || ifc.ch_ready !== 2'b00) begin errors++; $display("FAIL ref_excl got v=%b rdy=%b exp 0/00", ifc.sdram_valid, ifc.ch_ready); end
    ifc.refresh_req = 1'b0;
    t0 = cyc;
    wait_cmd(10, ok);
    checks++; if (!ok || ifc.ch_ready !== 2'b01 || cyc - t0 !== 4) begin errors++; $display("FAIL ref_resume got rdy=%b dt=%0d exp 01/4", ifc.ch_ready, cyc - t0); end
    ifc.ch_valid = 2'b00;
    repeat (4) tick();
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    ifc.ch_valid = 2'b10; ifc.ch_write = 2'b00; ifc.ch_address[21 +: 21] = 21'h00040;
    for (int g = 0; g < 4; g++) begin
      wait_cmd(10, ok);
      checks++; if (!ok || ifc.ch_ready !== 2'b10) begin errors++; $display("FAIL b2b_read%0d got ok=%b rdy=%b exp 10", g, ok, ifc.ch_ready); end
    end
    ifc.ch_valid = 2'b11; ifc.ch_write = 2'b01; ifc.ch_wdata[0 +: 32] = 32'h12345678; ifc.ch_wdata_mask[0 +: 4] = 4'b0101;
    wait_cmd(10, ok);
    checks++; if (!ok || ifc.ch_ready !== 2'b01 || ifc.sdram_write !== 1'b1) begin errors++; $display("FAIL b2b_write got ok=%b rdy=%b wr=%b exp 01/1", ok, ifc.ch_ready, ifc.sdram_write); end
    checks++; if (ifc.sdram_wdata !== 32'h12345678 || ifc.sdram_wdata_mask !== 4'b0101) begin errors++; $display("FAIL b2b_wdata got %h/%b exp 12345678/0101", ifc.sdram_wdata, ifc.sdram_wdata_mask); end
    ifc.ch_valid = 2'b10; ifc.ch_write = 2'b00;
    wait_cmd(10, ok);
    checks++; if (ok || rd_pending !== 3'd4) begin errors++; $display("FAIL b2b_full got issued=%b pend=%0d exp 0/4", ok, rd_pending); end
    return_one(32'h0000_0000);
    checks++; if (ifc.ch_rdata_en !== 2'b10 || rd_pending !== 3'd3) begin errors++; $display("FAIL b2b_ret got en=%b pend=%0d exp 10/3", ifc.ch_rdata_en, rd_pending); end
    wait_cmd(10, ok);
    checks++; if (!ok || ifc.ch_ready !== 2'b10 || ifc.sdram_write !== 1'b0) begin errors++; $display("FAIL b2b_fifth got ok=%b rdy=%b exp 10", ok, ifc.ch_ready); end
    ifc.ch_valid = 2'b00;
    tick();
    checks++; if (rd_pending !== 3'd4) begin errors++; $display("FAIL b2b_refill got %0d exp 4", rd_pending); end
    for (int r = 1; r <= 4; r++) begin
      return_one(32'hA000_0000 + 32'(r));
      checks++; if (ifc.ch_rdata_en !== 2'b10 || ifc.ch_rdata !== 32'hA000_0000 + 32'(r)) begin errors++; $display("FAIL b2b_drain%0d got en=%b d=%h", r, ifc.ch_rdata_en, ifc.ch_rdata); end
    end
    tick();
    checks++; if (rd_pending !== 3'd0) begin errors++; $display("FAIL b2b_empty got %0d exp 0", rd_pending); end
  endtask

  task automatic test_interleave();
    bit ok;
    logic [1:0]  chs [3];
    logic [20:0] adr [3];
    chs[0] = 2'b01; chs[1] = 2'b10; chs[2] = 2'b01;
    adr[0] = 21'h10; adr[1] = 21'h20; adr[2] = 21'h30;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      ifc.ch_valid = chs[i]; ifc.ch_write = 2'b00;
      ifc.ch_address[0 +: 21] = adr[i]; ifc.ch_address[21 +: 21] = adr[i];
      wait_cmd(10, ok);
      ifc.ch_valid = 2'b00;
      checks++; if (!ok || ifc.ch_ready !== chs[i] || ifc.sdram_address !== adr[i]) begin errors++; $display("FAIL il_issue%0d got rdy=%b a=%h exp %b/%h", i, ifc.ch_ready, ifc.sdram_address, chs[i], adr[i]); end
    end
    repeat (3) tick();
    checks++; if (rd_pending !== 3'd3) begin errors++; $display("FAIL il_pending got %0d exp 3", rd_pending); end
    for (int i = 0; i < 3; i++) begin
      return_one(32'hC0DE_0000 + 32'(i));
      checks++; if (ifc.ch_rdata_en !== chs[i] || ifc.ch_rdata !== 32'hC0DE_0000 + 32'(i)) begin errors++; $display("FAIL il_route%0d got en=%b d=%h exp %b", i, ifc.ch_rdata_en, ifc.ch_rdata, chs[i]); end
    end
    tick();
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL il_no_orphan got %b exp 0", err_orphan); end
    return_one(32'hBAD0BAD0);
    checks++; if (ifc.ch_rdata_en !== 2'b00 || err_orphan !== 1'b1) begin errors++; $display("FAIL il_orphan got en=%b err=%b exp 00/1", ifc.ch_rdata_en, err_orphan); end
    repeat (3) tick();
    checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL il_sticky got %b exp 1", err_orphan); end
  endtask

  task automatic test_init_and_reset();
    bit ok;
    int bad = 0;
    do_reset();
    initial_busy = 1'b1;
    ifc.ch_valid = 2'b01; ifc.ch_write = 2'b00; ifc.ch_address[0 +: 21] = 21'h00777;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (ifc.sdram_valid !== 1'b0 || ifc.ch_ready !== 2'b00) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL busy_block got %0d strobes exp 0", bad); end
    initial_busy = 1'b0;
    wait_cmd(1, ok);
    checks++; if (!ok || ifc.ch_ready !== 2'b01) begin errors++; $display("FAIL busy_release got ok=%b rdy=%b exp 1/01", ok, ifc.ch_ready); end
    ifc.ch_valid = 2'b00;
    tick();
    checks++; if (rd_pending !== 3'd1) begin errors++; $display("FAIL gap_pending got %0d exp 1", rd_pending); end
    reset_n = 1'b0;
    #1;
    checks++; if (rd_pending !== 3'd0 || ifc.sdram_valid !== 1'b0 || ifc.ch_ready !== 2'b00 || ifc.sdram_address !== 21'h0) begin errors++; $display("FAIL gap_reset got pend=%0d v=%b rdy=%b a=%h exp 0", rd_pending, ifc.sdram_valid, ifc.ch_ready, ifc.sdram_address); end
    tick();
    reset_n = 1'b1;
    tick();
    return_one(32'h1111_2222);
    checks++; if (err_orphan !== 1'b1 || ifc.ch_rdata_en !== 2'b00) begin errors++; $display("FAIL late_return got err=%b en=%b exp 1/00", err_orphan, ifc.ch_rdata_en); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_arbitration();
    test_refresh();
    test_back_to_back();
    test_interleave();
    test_init_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
